pipe_stage_reg: RTL

//  Generic, parametrised pipeline-stage register for the RV32 core. Successor to the fixed ID/EX latch.

---
 rtl/cpu_pipe_pkg.sv | 29 ++
 rtl/pipe_slot.sv | 61 ++++++
 rtl/pipe_stage_reg.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the RV32 pipeline-stage registers.
//   PC_RESET_DEFAULT : PC carried by an empty (bubble) stage
//   NOP_INSTR        : canonical RV32 nop (addi x0,x0,0)
//   REG_ADDR_W       : register-file address width
//   slot_state_e     : occupancy of the main/skid slot pair
//   slot_state()     : maps the two slot valid bits onto slot_state_e
package cpu_pipe_pkg;

   localparam logic [31:0] PC_RESET_DEFAULT = 32'h8000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam int          REG_ADDR_W       = 5;

   typedef enum logic [1:0] {
      SLOT_EMPTY = 2'd0,
      SLOT_ONE   = 2'd1,
      SLOT_FULL  = 2'd2
   } slot_state_e;

   // A skid entry without a main entry cannot occur; it decodes as empty.
   function automatic slot_state_e slot_state(input logic main_v, input logic skid_v);
      if (main_v && skid_v) begin
         return SLOT_FULL;
      end else if (main_v) begin
         return SLOT_ONE;
      end
      return SLOT_EMPTY;
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: a valid bit plus PC/rd/payload.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   valid_d_i      next value of the valid bit
//   load_i         capture pc_i/rd_i/payload_i (only when valid_d_i=1)
//   pc_i, rd_i, payload_i   data to capture
//   valid_o, pc_o, rd_o, payload_o   slot contents
// Whenever the slot ends a cycle empty its data registers take the bubble
// values, so an empty slot always presents PC_RESET / x0 / BUBBLE_PAYLOAD.
module pipe_slot
   import cpu_pipe_pkg::*;
#(
   parameter int                       ADDR_WIDTH     = 32,
   parameter int                       PAYLOAD_WIDTH  = 96,
   parameter logic [ADDR_WIDTH-1:0]    PC_RESET       = PC_RESET_DEFAULT,
   parameter logic [PAYLOAD_WIDTH-1:0] BUBBLE_PAYLOAD = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     valid_d_i,
   input  logic                     load_i,
   input  logic [ADDR_WIDTH-1:0]    pc_i,
   input  logic [REG_ADDR_W-1:0]    rd_i,
   input  logic [PAYLOAD_WIDTH-1:0] payload_i,
   output logic                     valid_o,
   output logic [ADDR_WIDTH-1:0]    pc_o,
   output logic [REG_ADDR_W-1:0]    rd_o,
   output logic [PAYLOAD_WIDTH-1:0] payload_o
);

   logic                     valid_q;
   logic [ADDR_WIDTH-1:0]    pc_q;
   logic [REG_ADDR_W-1:0]    rd_q;
   logic [PAYLOAD_WIDTH-1:0] payload_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q   <= 1'b0;
         pc_q      <= PC_RESET;
         rd_q      <= '0;
         payload_q <= BUBBLE_PAYLOAD;
      end else begin
         valid_q <= valid_d_i;
         if (!valid_d_i) begin
            pc_q      <= PC_RESET;
            rd_q      <= '0;
            payload_q <= BUBBLE_PAYLOAD;
         end else if (load_i) begin
            pc_q      <= pc_i;
            rd_q      <= rd_i;
            payload_q <= payload_i;
         end
      end
   end

   assign valid_o   = valid_q;
   assign pc_o      = pc_q;
   assign rd_o      = rd_q;
   assign payload_o = payload_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   flush                       drop held entries and the same-cycle input
//   in_valid/in_ready           upstream handshake
//   in_pc/in_rd_addr/in_payload upstream entry
//   out_valid/out_ready         downstream handshake
//   out_pc/out_rd_addr/out_payload  head entry (bubble values when empty)
//   stall_cnt                   saturating count of out_valid && !out_ready cycles
// SKID=0 uses one slot with a combinational in_ready; SKID=1 adds a skid slot
// so in_ready comes straight from a flop.
module pipe_stage_reg
   import cpu_pipe_pkg::*;
#(
   parameter int                       ADDR_WIDTH     = 32,
   parameter int                       PAYLOAD_WIDTH  = 96,
   parameter int                       SKID           = 0,
   parameter logic [ADDR_WIDTH-1:0]    PC_RESET       = PC_RESET_DEFAULT,
   parameter logic [PAYLOAD_WIDTH-1:0] BUBBLE_PAYLOAD = '0,
   parameter int                       CNT_WIDTH      = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_WIDTH-1:0]    in_pc,
   input  logic [REG_ADDR_W-1:0]    in_rd_addr,
   input  logic [PAYLOAD_WIDTH-1:0] in_payload,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ADDR_WIDTH-1:0]    out_pc,
   output logic [REG_ADDR_W-1:0]    out_rd_addr,
   output logic [PAYLOAD_WIDTH-1:0] out_payload,
   output logic [CNT_WIDTH-1:0]     stall_cnt
);

   localparam int NSLOTS = (SKID != 0) ? 2 : 1;

   // Index 0 is the main (head) slot, index 1 the skid slot.
   logic [1:0]               slot_valid_d;
   logic [1:0]               slot_load;
   logic [1:0]               slot_valid_q;
   logic [ADDR_WIDTH-1:0]    slot_pc_in      [2];
   logic [REG_ADDR_W-1:0]    slot_rd_in      [2];
   logic [PAYLOAD_WIDTH-1:0] slot_payload_in [2];
   logic [ADDR_WIDTH-1:0]    slot_pc_q       [2];
   logic [REG_ADDR_W-1:0]    slot_rd_q       [2];
   logic [PAYLOAD_WIDTH-1:0] slot_payload_q  [2];

   logic        push;
   logic        pop;
   logic        take;
   logic        main_from_skid;
   slot_state_e state;

   logic [CNT_WIDTH-1:0] stall_cnt_q;
   logic [CNT_WIDTH-1:0] stall_cnt_d;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_slot
         if (gi < NSLOTS) begin : g_inst
            pipe_slot #(
               .ADDR_WIDTH     (ADDR_WIDTH),
               .PAYLOAD_WIDTH  (PAYLOAD_WIDTH),
               .PC_RESET       (PC_RESET),
               .BUBBLE_PAYLOAD (BUBBLE_PAYLOAD)
            ) u_slot (
               .clk       (clk),
               .reset     (reset),
               .valid_d_i (slot_valid_d[gi]),
               .load_i    (slot_load[gi]),
               .pc_i      (slot_pc_in[gi]),
               .rd_i      (slot_rd_in[gi]),
               .payload_i (slot_payload_in[gi]),
               .valid_o   (slot_valid_q[gi]),
               .pc_o      (slot_pc_q[gi]),
               .rd_o      (slot_rd_q[gi]),
               .payload_o (slot_payload_q[gi])
            );
         end else begin : g_tie
            assign slot_valid_q[gi]   = 1'b0;
            assign slot_pc_q[gi]      = PC_RESET;
            assign slot_rd_q[gi]      = '0;
            assign slot_payload_q[gi] = BUBBLE_PAYLOAD;
         end
      end
   endgenerate

   assign out_valid   = slot_valid_q[0];
   assign out_pc      = slot_pc_q[0];
   assign out_rd_addr = slot_valid_q[0] ? slot_rd_q[0] : '0;
   assign out_payload = slot_payload_q[0];

   // Without a skid slot the stage can only accept when the head leaves.
   assign in_ready = (SKID != 0) ? !slot_valid_q[1] : (!slot_valid_q[0] || out_ready);

   assign push  = in_valid && in_ready;
   assign pop   = out_valid && out_ready;
   // A flushed input is discarded even though the handshake completed.
   assign take  = push && !flush;
   assign state = slot_state(slot_valid_q[0], slot_valid_q[1]);

   always_comb begin
      slot_valid_d   = slot_valid_q;
      slot_load      = 2'b00;
      main_from_skid = 1'b0;

      if (SKID == 0) begin
         if (pop) begin
            slot_valid_d[0] = 1'b0;
         end
         if (take) begin
            slot_valid_d[0] = 1'b1;
            slot_load[0]    = 1'b1;
         end
      end else begin
         unique case (state)
            SLOT_EMPTY: begin
               if (take) begin
                  slot_valid_d[0] = 1'b1;
                  slot_load[0]    = 1'b1;
               end
            end
            SLOT_ONE: begin
               if (take && pop) begin
                  slot_load[0] = 1'b1;
               end else if (take) begin
                  slot_valid_d[1] = 1'b1;
                  slot_load[1]    = 1'b1;
               end else if (pop) begin
                  slot_valid_d[0] = 1'b0;
               end
            end
            SLOT_FULL: begin
               if (pop) begin
                  slot_load[0]    = 1'b1;
                  main_from_skid  = 1'b1;
                  slot_valid_d[1] = 1'b0;
               end
            end
            default: begin
               slot_valid_d = 2'b00;
            end
         endcase
      end

      if (flush) begin
         slot_valid_d = 2'b00;
      end
   end

   always_comb begin
      slot_pc_in[0]      = main_from_skid ? slot_pc_q[1]      : in_pc;
      slot_rd_in[0]      = main_from_skid ? slot_rd_q[1]      : in_rd_addr;
      slot_payload_in[0] = main_from_skid ? slot_payload_q[1] : in_payload;
      slot_pc_in[1]      = in_pc;
      slot_rd_in[1]      = in_rd_addr;
      slot_payload_in[1] = in_payload;
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid && !out_ready && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule
